// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state and latency-counter width for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - synchronous single-port word RAM with per-byte-lane write enables
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read returns the pre-write word; only loads consume rdata.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - one-outstanding load/store responder with fixed latency; DMEM_WSTRB_EN adds req_wstrb
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
    input  logic [3:0]  req_wstrb,
`endif
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t               state;
    logic [LAT_CNT_W-1:0] cnt;
    logic                 lat_write;
    logic                 lat_err;
    logic [AW-1:0]        lat_idx;
    logic [31:0]          lat_wdata;
    logic [3:0]           lat_lanes;

    logic                 req_err;
    logic [3:0]           req_lanes;
    logic                 accept;
    logic                 enter_resp;
    logic                 cur_write;
    logic                 cur_err;
    logic [AW-1:0]        cur_idx;
    logic [31:0]          cur_wdata;
    logic [3:0]           cur_lanes;
    logic [31:0]          ram_rdata;

`ifdef DMEM_WSTRB_EN
    assign req_lanes = req_wstrb;
`else
    assign req_lanes = 4'hF;
`endif

    assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
    assign accept  = (state == IDLE) && req_valid;

    // With zero latency the array is touched on the accept edge, so it sees the live request.
    assign enter_resp = (accept && (LATENCY == 0)) || ((state == WAIT) && (cnt == LAT_LAST));

    always_comb begin
        cur_write = lat_write;
        cur_err   = lat_err;
        cur_idx   = lat_idx;
        cur_wdata = lat_wdata;
        cur_lanes = lat_lanes;
        if (state == IDLE) begin
            cur_write = req_write;
            cur_err   = req_err;
            cur_idx   = req_addr[AW+1:2];
            cur_wdata = req_wdata;
            cur_lanes = req_lanes;
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .en    (enter_resp && !rst && !cur_err),
        .we    (cur_write ? cur_lanes : 4'b0000),
        .addr  (cur_idx),
        .wdata (cur_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_lanes <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_err   <= req_err;
                        lat_idx   <= req_addr[AW+1:2];
                        lat_wdata <= req_wdata;
                        lat_lanes <= req_lanes;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        if (enter_resp) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= req_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (enter_resp) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_err;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The array output only changes on an enabled edge, so this stays stable through RESP.
    assign rsp_rdata = (rsp_valid && !lat_write && !rsp_err) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder (LATENCY=2 and LATENCY=0 instances)
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
    logic [3:0]  z_req_wstrb;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [0:255];
    logic [32:0] sb_q [$];

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) u0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_WSTRB_EN
        .req_wstrb (req_wstrb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u1 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_write (z_req_write),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
`ifdef DMEM_WSTRB_EN
        .req_wstrb (z_req_wstrb),
`endif
        .rsp_valid (z_rsp_valid),
        .rsp_ready (z_rsp_ready),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one request on u0, model its effect, then wait for and check the response.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, input string tag);
        logic [32:0] exp;
        logic        err;
        logic [3:0]  lanes;
        int          n;
        err = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
`ifdef DMEM_WSTRB_EN
        lanes = s;
`else
        lanes = 4'hF;
`endif
        if (w && !err)
            for (int i = 0; i < 4; i++)
                if (lanes[i]) model[a[9:2]][8*i +: 8] = d[8*i +: 8];
        sb_q.push_back({err, (w || err) ? 32'd0 : model[a[9:2]]});

        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = (hold == 0);
        chk({tag, "/req_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 1;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "/latency"}, n, LAT + 1);
        exp = sb_q.pop_front();
        chk({tag, "/rdata"}, rsp_rdata, exp[31:0]);
        chk({tag, "/err"}, {31'd0, rsp_err}, {31'd0, exp[32]});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "/hold_ready"}, {31'd0, req_ready}, 32'd0);
            chk({tag, "/hold_rdata"}, rsp_rdata, exp[31:0]);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/done_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "/done_ready"}, {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 4'hF; rsp_ready = 0;
        z_req_valid = 0; z_req_write = 0; z_req_addr = 0; z_req_wdata = 0; z_req_wstrb = 4'hF; z_rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst/req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst/rsp_rdata", rsp_rdata, 32'd0);
        chk("rst/rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst/z_req_ready", {31'd0, z_req_ready}, 32'd1);

        xact(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 0, "init_w0");
        xact(1'b1, 32'h20, 32'h01020304, 4'hF, 0, "init_w20");
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st_10");
        xact(1'b0, 32'h10, 32'h0, 4'hF, 0, "ld_10");
        xact(1'b0, 32'h12, 32'h0, 4'hF, 0, "ld_misaligned");
        xact(1'b1, 32'h400, 32'h12345678, 4'hF, 0, "st_range");
        xact(1'b0, 32'h0, 32'h0, 4'hF, 0, "ld_w0");
        xact(1'b0, 32'h10, 32'h0, 4'hF, 5, "ld_hold");

        // Reset on the edge that would otherwise commit the store.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstwait/rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rstwait/req_ready", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b0;
        xact(1'b0, 32'h20, 32'h0, 4'hF, 0, "ld_20_after_rst");

`ifdef DMEM_WSTRB_EN
        xact(1'b1, 32'h8, 32'h11223344, 4'hF, 0, "wstrb_init");
        xact(1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 0, "wstrb_0101");
        xact(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, 0, "wstrb_none");
        xact(1'b0, 32'h8, 32'h0, 4'hF, 0, "wstrb_ld");
`endif

        // LATENCY=0 instance: back-to-back store then load with rsp_ready tied high.
        @(posedge clk); #1;
        z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h4; z_req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        chk("lat0/st_valid", {31'd0, z_rsp_valid}, 32'd1);
        chk("lat0/st_err", {31'd0, z_rsp_err}, 32'd0);
        chk("lat0/st_ready", {31'd0, z_req_ready}, 32'd0);
        z_req_write = 1'b0;
        @(posedge clk); #1;
        chk("lat0/gap_valid", {31'd0, z_rsp_valid}, 32'd0);
        chk("lat0/gap_ready", {31'd0, z_req_ready}, 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk("lat0/ld_valid", {31'd0, z_rsp_valid}, 32'd1);
        chk("lat0/ld_rdata", z_rsp_rdata, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("lat0/end_valid", {31'd0, z_rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
